// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and flag bit positions for alu_seq
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_INC = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_ADC = 4'b1000;
    localparam logic [3:0] OP_SBC = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_ASR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_CMP = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational single-cycle ALU operations and flags
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzvc,
    output logic             wr_result,
    output logic             wr_flags
);

    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] logic_r;
    logic [WIDTH:0]   sum;
    logic             ci;
    logic             is_sub;
    logic             arith;
    logic             ovf;

    // Decode the opcode into an adder/subtractor setup or a bitwise result, then derive flags
    always_comb begin
        opb       = b;
        ci        = 1'b0;
        is_sub    = 1'b0;
        arith     = 1'b1;
        logic_r   = '0;
        wr_result = 1'b1;
        wr_flags  = 1'b1;
        case (op)
            OP_ADD: ;
            OP_INC: opb = WIDTH'(1);
            OP_SUB: is_sub = 1'b1;
            OP_DEC: begin is_sub = 1'b1; opb = WIDTH'(1); end
            OP_ADC: ci = cin;
            OP_SBC: begin is_sub = 1'b1; ci = cin; end
            OP_CMP: begin is_sub = 1'b1; wr_result = 1'b0; end
            OP_AND: begin arith = 1'b0; logic_r = a & b; end
            OP_OR:  begin arith = 1'b0; logic_r = a | b; end
            OP_XOR: begin arith = 1'b0; logic_r = a ^ b; end
            OP_NOT: begin arith = 1'b0; logic_r = ~a; end
            default: begin wr_result = 1'b0; wr_flags = 1'b0; end
        endcase

        // Bit WIDTH of the difference is the borrow: set exactly when a < opb + ci
        if (is_sub) begin
            sum = {1'b0, a} - {1'b0, opb} - {{WIDTH{1'b0}}, ci};
            ovf = (a[WIDTH-1] != opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, ci};
            ovf = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end

        result       = arith ? sum[WIDTH-1:0] : logic_r;
        nzvc         = '0;
        nzvc[FLAG_N] = result[WIDTH-1];
        nzvc[FLAG_Z] = (result == '0);
        nzvc[FLAG_V] = arith & ovf;
        nzvc[FLAG_C] = arith & sum[WIDTH];
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle ops, iterative shifts and shift-add multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       NZVC,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               c_q, c_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         nzvc_q, nzvc_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               complete;
    logic [WIDTH-1:0]   core_result;
    logic [3:0]         core_nzvc;
    logic               core_wr_result;
    logic               core_wr_flags;

    // Carry-in is read when the op executes, so a back-to-back ADC/SBC sees the previous op's carry
    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .cin       (nzvc_q[FLAG_C]),
        .result    (core_result),
        .nzvc      (core_nzvc),
        .wr_result (core_wr_result),
        .wr_flags  (core_wr_flags)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign NZVC      = nzvc_q;

    // Next-state: finish a pending op, iterate a multi-cycle op, or accept a new operation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        c_d         = c_q;
        pend_d      = 1'b0;
        result_d    = result_q;
        nzvc_d      = nzvc_q;
        out_valid_d = 1'b0;
        complete    = 1'b0;
        accept      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                complete = pend_q;
                accept   = in_valid;
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    case (op_q)
                        OP_SHL: begin c_d = a_q[WIDTH-1]; a_d = {a_q[WIDTH-2:0], 1'b0}; end
                        OP_SHR: begin c_d = a_q[0];       a_d = {1'b0, a_q[WIDTH-1:1]}; end
                        OP_ASR: begin c_d = a_q[0];       a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; end
                        default: begin
                            // MSB-first shift-add: double the partial product, add A when the multiplier bit is set
                            prod_d = {prod_q[2*WIDTH-2:0], 1'b0}
                                   + {{WIDTH{1'b0}}, (b_q[WIDTH-1] ? a_q : {WIDTH{1'b0}})};
                            b_d    = {b_q[WIDTH-2:0], 1'b0};
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            out_valid_d = 1'b1;
            if (is_shift(op_q)) begin
                result_d = a_q;
                nzvc_d   = {a_q[WIDTH-1], (a_q == '0), 1'b0, c_q};
            end else if (op_q == OP_MUL) begin
                result_d = prod_q[WIDTH-1:0];
                nzvc_d   = {prod_q[WIDTH-1], (prod_q[WIDTH-1:0] == '0),
                            (prod_q[2*WIDTH-1:WIDTH] != '0), 1'b0};
            end else begin
                if (core_wr_result) result_d = core_result;
                if (core_wr_flags)  nzvc_d   = core_nzvc;
            end
        end

        if (accept) begin
            op_d   = ALU_Sel;
            a_d    = A;
            b_d    = B;
            c_d    = 1'b0;
            prod_d = '0;
            cnt_d  = '0;
            if (is_shift(ALU_Sel)) begin
                cnt_d = CW'(B[SHW-1:0]);
                if (B[SHW-1:0] != '0) state_d = ST_BUSY;
                else                  pend_d  = 1'b1;
            end else if (ALU_Sel == OP_MUL) begin
                cnt_d   = CW'(WIDTH);
                state_d = ST_BUSY;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset that also aborts any op in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            c_q         <= 1'b0;
            pend_q      <= 1'b0;
            result_q    <= '0;
            nzvc_q      <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            c_q         <= c_d;
            pend_q      <= pend_d;
            result_q    <= result_d;
            nzvc_q      <= nzvc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [3:0] ALU_Sel = 4'hF;
    logic       out_valid;
    logic [7:0] Result;
    logic [3:0] NZVC;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_res  = 8'h00;
    logic [3:0] m_nzvc = 4'h0;

    logic [3:0] bo [3];
    logic [7:0] ba [3];
    logic [7:0] bb [3];
    logic [7:0] er [3];
    logic [3:0] ef [3];

    alu_seq #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .out_valid (out_valid),
        .Result    (Result),
        .NZVC      (NZVC),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: 8-bit ISA semantics in plain integer arithmetic, ops complete in program order
    task automatic model(input logic [3:0] op, input int a, input int b, output int lat);
        int r, full, ss, n, cin, addb, ci;
        logic c, v, wr_r, wr_f;
        cin  = m_nzvc[0] ? 1 : 0;
        n    = b % 8;
        addb = (op == 4'h1 || op == 4'h3) ? 1 : b;
        ci   = (op == 4'h8 || op == 4'h9) ? cin : 0;
        lat  = 1; r = 0; full = 0; ss = 0;
        c = 1'b0; v = 1'b0; wr_r = 1'b1; wr_f = 1'b1;
        case (op)
            4'h0, 4'h1, 4'h8: begin
                full = a + addb + ci;
                r    = full % 256;
                c    = (full > 255);
                ss   = sx(a) + sx(addb) + ci;
                v    = (ss > 127) || (ss < -128);
            end
            4'h2, 4'h3, 4'h9, 4'hE: begin
                r    = (a - addb - ci) & 255;
                c    = (a < addb + ci);
                ss   = sx(a) - sx(addb) - ci;
                v    = (ss > 127) || (ss < -128);
                wr_r = (op != 4'hE);
            end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = (~a) & 255;
            4'hA: begin
                r = (a << n) & 255;
                c = (n > 0) && (((a >> (8 - n)) & 1) != 0);
                lat = n + 1;
            end
            4'hB: begin
                r = a >> n;
                c = (n > 0) && (((a >> (n - 1)) & 1) != 0);
                lat = n + 1;
            end
            4'hC: begin
                r = (sx(a) >>> n) & 255;
                c = (n > 0) && (((sx(a) >>> (n - 1)) & 1) != 0);
                lat = n + 1;
            end
            4'hD: begin
                full = a * b;
                r    = full & 255;
                v    = (full > 255);
                lat  = 9;
            end
            default: begin wr_r = 1'b0; wr_f = 1'b0; end
        endcase
        if (wr_r) m_res = r[7:0];
        if (wr_f) m_nzvc = {(r >= 128), (r == 0), v, c};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        m_res = 8'h00;
        m_nzvc = 4'h0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int lat_exp, lat_obs, w;
        model(op, int'(a), int'(b), lat_exp);
        w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        check("in_ready wait", (w < 50), 1);
        in_valid = 1'b1; ALU_Sel = op; A = a; B = b;
        step();
        in_valid = 1'b0;
        lat_obs = 0;
        do begin step(); lat_obs++; end while (!out_valid && lat_obs < 30);
        check($sformatf("op%0h a=%0h b=%0h latency", op, a, b), lat_obs, lat_exp);
        check($sformatf("op%0h a=%0h b=%0h Result", op, a, b), Result, m_res);
        check($sformatf("op%0h a=%0h b=%0h NZVC", op, a, b), NZVC, m_nzvc);
    endtask

    // Issues n single-cycle ops on consecutive edges and checks each completion against er/ef
    task automatic b2b(input int n);
        int dummy;
        for (int i = 0; i < n; i++) model(bo[i], int'(ba[i]), int'(bb[i]), dummy);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                in_valid = 1'b1; ALU_Sel = bo[i]; A = ba[i]; B = bb[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            check($sformatf("b2b%0d in_ready", i), in_ready, 1);
            check($sformatf("b2b%0d out_valid", i), out_valid, (i > 0));
            if (i > 0) begin
                check($sformatf("b2b%0d Result", i), Result, er[i-1]);
                check($sformatf("b2b%0d NZVC", i), NZVC, ef[i-1]);
            end
        end
        step();
        check("b2b out_valid drop", out_valid, 0);
    endtask

    initial begin
        int seen, dummy;
        logic [3:0] rop;
        logic [7:0] ra, rb;

        do_reset();
        check("reset Result", Result, 8'h00);
        check("reset NZVC", NZVC, 4'b0000);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 1);

        run_op(4'h0, 8'h7F, 8'h01);
        check("add7f Result", Result, 8'h80);
        check("add7f NZVC", NZVC, 4'b1010);
        run_op(4'h0, 8'hFF, 8'h01);
        check("addff Result", Result, 8'h00);
        check("addff NZVC", NZVC, 4'b0101);

        bo[0] = 4'h2; ba[0] = 8'h10; bb[0] = 8'h20; er[0] = 8'hF0; ef[0] = 4'b1001;
        bo[1] = 4'h9; ba[1] = 8'h05; bb[1] = 8'h02; er[1] = 8'h02; ef[1] = 4'b0000;
        b2b(2);

        // SHL 0x81 by 3 with a competing op held on in_valid throughout the busy window
        model(4'hA, 32'h81, 3, dummy);
        in_valid = 1'b1; ALU_Sel = 4'hA; A = 8'h81; B = 8'h03;
        step();
        ALU_Sel = 4'h0; A = 8'h11; B = 8'h22;
        check("shl accept busy", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("shl cyc%0d busy", i), busy, 1);
            check($sformatf("shl cyc%0d in_ready", i), in_ready, 0);
            check($sformatf("shl cyc%0d out_valid", i), out_valid, 0);
            check($sformatf("shl cyc%0d Result held", i), Result, 8'h02);
        end
        step();
        in_valid = 1'b0;
        check("shl out_valid", out_valid, 1);
        check("shl Result", Result, 8'h08);
        check("shl NZVC", NZVC, 4'b0000);
        check("shl busy done", busy, 0);
        step();
        step();
        check("shl ignored op", out_valid, 0);
        check("shl ignored Result", Result, 8'h08);

        run_op(4'hD, 8'h10, 8'h10);
        check("mul16 Result", Result, 8'h00);
        check("mul16 NZVC", NZVC, 4'b0110);
        run_op(4'hD, 8'h0C, 8'h0B);
        check("mul12 Result", Result, 8'h84);
        check("mul12 NZVC", NZVC, 4'b1000);

        // Reset on the 4th cycle of a MUL aborts it
        in_valid = 1'b1; ALU_Sel = 4'hD; A = 8'hFF; B = 8'hFF;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_res = 8'h00; m_nzvc = 4'h0;
        check("abort out_valid", out_valid, 0);
        check("abort Result", Result, 8'h00);
        check("abort NZVC", NZVC, 4'b0000);
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("abort no late pulse", seen, 0);

        // Reset wins over a simultaneous in_valid
        run_op(4'h0, 8'h20, 8'h30);
        reset = 1'b1; in_valid = 1'b1; ALU_Sel = 4'h0; A = 8'h05; B = 8'h05;
        step();
        reset = 1'b0; in_valid = 1'b0;
        m_res = 8'h00; m_nzvc = 4'h0;
        step();
        check("rst prio out_valid", out_valid, 0);
        check("rst prio Result", Result, 8'h00);

        bo[0] = 4'h4; ba[0] = 8'h3C; bb[0] = 8'h0F; er[0] = 8'h0C; ef[0] = 4'b0000;
        bo[1] = 4'hE; ba[1] = 8'h33; bb[1] = 8'h33; er[1] = 8'h0C; ef[1] = 4'b0100;
        bo[2] = 4'hF; ba[2] = 8'hAA; bb[2] = 8'h55; er[2] = 8'h0C; ef[2] = 4'b0100;
        b2b(3);

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            run_op(rop, ra, rb);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
